sine_voice: RTL and testbench
=============================

Name: sine_voice

Overview:
Wavetable oscillator voice that reads the 256x12 sine ROM. It is the ROM's read-side client. On each audio sample tick it advances a phase accumulator and issues a ROM address. One cycle later it captures the ROM data, removes the offset, scales it by a 4-bit volume and presents a signed sample with a valid pulse. It sits between the step-sequencer note/gate logic and the audio mixer/codec path.

Parameters:
ACC_W, 32, phase accumulator width in bits (must be >= 9)
ROM_AW, 8, ROM address width; address = top ROM_AW bits of phase
ROM_DW, 12, ROM data width; unsigned, midscale = 2^(ROM_DW-1)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
sample_tick  input  1  one-cycle strobe requesting the next sample
gate  input  1  note on (1) / off (0)
tune_word  input  ACC_W  phase increment per sample tick
volume  input  4  unsigned amplitude scale, 0..15
rom_address  output  ROM_AW  address to sine ROM
rom_q  input  ROM_DW  ROM data, registered by ROM one edge after rom_address
sample  output  16  signed two's-complement output sample
sample_valid  output  1  one-cycle pulse, sample updated
busy  output  1  high while a sample request is in flight
overrun  output  1  sticky: sample_tick arrived while busy

Behaviour:
- Reset (synchronous, active-high, sampled on clock edge): phase=0, rom_address=0, sample=0, sample_valid=0, busy=0, overrun=0, state=IDLE. Reset overrides every other input and aborts any in-flight request; no sample_valid is emitted for the aborted request.
- Gate: while gate=0, phase is forced to 0 every cycle. This guarantees each note starts at phase 0.
- FSM states: IDLE, READ, CAPTURE.
- IDLE: if sample_tick=1 at edge N: rom_address <= phase[ACC_W-1 -: ROM_AW] (pre-increment phase); phase <= gate ? phase + tune_word : 0; latch volume and gate into vol_r, gate_r; busy <= 1; go to READ.
- READ (edge N+1): the ROM registers mem[rom_address]; go to CAPTURE.
- CAPTURE (edge N+2):
  - centred = rom_q - 2^(ROM_DW-1), signed ROM_DW+1 bits.
  - sample <= gate_r ? sign-extend(centred * vol_r) : 0.
  - sample_valid <= 1 for exactly this cycle; busy <= 0; go to IDLE.
- Latency: tick sampled at edge N -> sample/sample_valid visible after edge N+2. Maximum tick rate is one per 3 cycles. A tick may be accepted in the cycle after sample_valid (IDLE).
- Arithmetic: phase addition wraps modulo 2^ACC_W with no saturation. The product centred*vol_r ranges -30720..+30705 and is stored in 16-bit signed without overflow.
- sample holds its value between valid pulses.
- Boundary cases:
  - sample_tick while busy (READ/CAPTURE): ignored; phase unchanged; overrun <= 1 until reset.
  - gate falling mid-request: the in-flight sample uses the latched gate_r; phase is cleared.
  - tune_word and volume changes mid-request: no effect until the next tick.
  - volume=0 -> sample 0 with valid still pulsed.

Test Plan:
1. Reset: assert reset 2 cycles mid-request (tick, then reset at edge N+1) -> all outputs 0; no sample_valid at N+2; busy=0.
2. Tick timing: gate=1, tune_word=0x01000000, volume=15, ROM loaded with sine256.hex, ticks every 4 cycles -> rom_address 0,1,2,3…; sample_valid exactly 2 edges after each tick. First sample: q=0x800 -> sample=0.
3. Peak amplitude: drive phase to address 64 (q=0xFFF) with volume=15 -> sample=30705. At address 192 (q=0x001) with volume=1 -> sample=-2047.
4. Gate off: gate=0, tick -> sample=0 with valid pulse, phase stays 0. Raise gate, tick -> rom_address=0.
5. Wrap-around: tune_word=0x80000000, 3 ticks -> rom_address 0x00, 0x80, 0x00. Phase wraps with no other flag.
6. Overrun: ticks on two consecutive cycles -> one sample_valid, second tick ignored, overrun=1 sticky until reset.

Source files
------------

// File: rtl/sine_voice_if.sv
// Signal bundle between the sine voice, its sine ROM and the sequencer/mixer side.
// slave: the voice itself; master: whoever drives ticks/notes and hosts the ROM.
interface sine_voice_if #(
  parameter int ACC_W  = 32,
  parameter int ROM_AW = 8,
  parameter int ROM_DW = 12
);
  logic                     sample_tick;
  logic                     gate;
  logic [ACC_W-1:0]         tune_word;
  logic [3:0]               volume;
  logic [ROM_AW-1:0]        rom_address;
  logic [ROM_DW-1:0]        rom_q;
  logic signed [15:0]       sample;
  logic                     sample_valid;
  logic                     busy;
  logic                     overrun;

  modport slave (
    input  sample_tick, gate, tune_word, volume, rom_q,
    output rom_address, sample, sample_valid, busy, overrun
  );

  modport master (
    output sample_tick, gate, tune_word, volume, rom_q,
    input  rom_address, sample, sample_valid, busy, overrun
  );
endinterface

// File: rtl/sine_voice.sv
// Wavetable sine voice: phase accumulator -> ROM address, then offset removal and
// 4-bit volume scaling of the registered ROM word into a signed 16-bit sample.
module sine_voice #(
  parameter int ACC_W  = 32,
  parameter int ROM_AW = 8,
  parameter int ROM_DW = 12
) (
  input  logic        clock,
  input  logic        reset,
  sine_voice_if.slave bus
);

  localparam int PW = ROM_DW + 6;

  typedef enum logic [1:0] {IDLE, READ, CAPTURE} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     w_accept;
  logic [ACC_W-1:0]         r_phase;
  logic [ROM_AW-1:0]        r_addr_p0;
  logic [3:0]               r_vol_p0;
  logic                     r_gate_p0;
  logic signed [15:0]       r_sample_p2;
  logic                     r_vld_p2;
  logic                     r_busy;
  logic                     r_overrun;

  // Centre the unsigned ROM word around zero and scale by volume; the product
  // always fits 16 bits signed, so the final cast never drops significant bits.
  function automatic logic signed [15:0] scale_sample(
    input logic [ROM_DW-1:0] q,
    input logic [3:0]        vol,
    input logic              en
  );
    logic signed [ROM_DW:0] centred;
    logic signed [PW-1:0]   prod;
    centred = $signed({1'b0, q}) - $signed({2'b01, {(ROM_DW-1){1'b0}}});
    prod    = PW'(centred) * PW'($signed({1'b0, vol}));
    if (!en) return '0;
    return 16'(prod);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.sample_tick) begin
          w_accept = 1'b1;
          w_next   = READ;
        end
      end
      READ:    w_next = CAPTURE;
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase     <= '0;
      r_addr_p0   <= '0;
      r_vol_p0    <= '0;
      r_gate_p0   <= 1'b0;
      r_sample_p2 <= '0;
      r_vld_p2    <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_vld_p2 <= 1'b0;

      // Gate low pins the phase to zero so every note starts at phase 0.
      if (!bus.gate)     r_phase <= '0;
      else if (w_accept) r_phase <= r_phase + bus.tune_word;

      // Stage p0: address from the pre-increment phase, note parameters latched.
      if (w_accept) begin
        r_addr_p0 <= r_phase[ACC_W-1 -: ROM_AW];
        r_vol_p0  <= bus.volume;
        r_gate_p0 <= bus.gate;
        r_busy    <= 1'b1;
      end

      if (bus.sample_tick && (r_state != IDLE)) r_overrun <= 1'b1;

      // Stage p2: ROM word registered during READ is scaled and presented.
      if (r_state == CAPTURE) begin
        r_sample_p2 <= scale_sample(bus.rom_q, r_vol_p0, r_gate_p0);
        r_vld_p2    <= 1'b1;
        r_busy      <= 1'b0;
      end
    end
  end

  assign bus.rom_address  = r_addr_p0;
  assign bus.sample       = r_sample_p2;
  assign bus.sample_valid = r_vld_p2;
  assign bus.busy         = r_busy;
  assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_sine_voice.sv
// Scoreboard bench for sine_voice: a sample-level reference model queues expected
// samples on accepted ticks; a negedge monitor pops and compares on sample_valid.
module tb_sine_voice;

  logic clk;
  logic rst;

  sine_voice_if #(.ACC_W(32), .ROM_AW(8), .ROM_DW(12)) bus ();

  sine_voice #(.ACC_W(32), .ROM_AW(8), .ROM_DW(12)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] mem [256];

  always @(posedge clk) bus.rom_q <= mem[bus.rom_address];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: one sample in flight at a time, three cycles per request.
  typedef struct {
    int due;
    int smp;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc        = 0;
  int          m_cnt      = 0;
  logic [31:0] m_phase    = '0;
  logic [7:0]  m_addr     = '0;
  bit          m_ovr      = 1'b0;
  int          m_hold     = 0;
  bit          m_pend     = 1'b0;
  int          m_pend_due = 0;
  int          m_pend_smp = 0;

  always @(posedge clk) begin
    bit acc;
    int s;
    cyc++;
    if (rst) begin
      m_phase = '0;
      m_addr  = '0;
      m_cnt   = 0;
      m_ovr   = 1'b0;
      m_hold  = 0;
      m_pend  = 1'b0;
      exp_q.delete();
    end else begin
      acc = bus.sample_tick && (m_cnt == 0);
      if (bus.sample_tick && (m_cnt != 0)) m_ovr = 1'b1;
      if (m_cnt > 0) m_cnt--;
      if (m_pend && (m_pend_due == cyc)) begin
        m_hold = m_pend_smp;
        m_pend = 1'b0;
      end
      if (acc) begin
        m_addr = m_phase[31:24];
        s = bus.gate ? (int'(mem[m_addr]) - 2048) * int'(bus.volume) : 0;
        exp_q.push_back('{cyc + 2, s});
        m_pend     = 1'b1;
        m_pend_due = cyc + 2;
        m_pend_smp = s;
        m_cnt      = 2;
      end
      if (!bus.gate) m_phase = '0;
      else if (acc)  m_phase = m_phase + bus.tune_word;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("busy", int'(bus.busy), int'(m_cnt != 0));
    chk("overrun", int'(bus.overrun), int'(m_ovr));
    chk("rom_address", int'(bus.rom_address), int'(m_addr));
    if (bus.sample_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got sample_valid=1 at cycle %0d expected 0", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("valid_latency", cyc, e.due);
        chk("sample", int'(bus.sample), e.smp);
      end
    end else begin
      if ((exp_q.size() != 0) && (exp_q[0].due <= cyc)) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_valid: got sample_valid=0 at cycle %0d expected 1", cyc);
      end
      chk("sample_hold", int'(bus.sample), m_hold);
    end
  end

  task automatic do_tick(input bit g, input logic [31:0] tw, input logic [3:0] v);
    @(posedge clk);
    #1;
    bus.sample_tick = 1'b1;
    bus.gate        = g;
    bus.tune_word   = tw;
    bus.volume      = v;
    @(posedge clk);
    #1;
    bus.sample_tick = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int s);
    s = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.sample_valid) begin
        s = int'(bus.sample);
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no sample_valid within 8 cycles expected a pulse", nm);
  endtask

  task automatic idle(input int n, input bit g);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.sample_tick = 1'b0;
      bus.gate        = g;
    end
  endtask

  initial begin
    real r;
    int  v;
    int  s;
    for (int i = 0; i < 256; i++) begin
      r = 2047.0 * $sin(2.0 * 3.14159265358979 * i / 256.0);
      v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
      mem[i] = 12'(2048 + v);
    end

    rst             = 1'b1;
    bus.sample_tick = 1'b0;
    bus.gate        = 1'b0;
    bus.tune_word   = '0;
    bus.volume      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset arriving one edge after an accepted tick aborts it.
    @(posedge clk);
    #1;
    bus.sample_tick = 1'b1;
    bus.gate        = 1'b1;
    bus.tune_word   = 32'h0100_0000;
    bus.volume      = 4'd15;
    @(posedge clk);
    #1;
    bus.sample_tick = 1'b0;
    rst             = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_sample", int'(bus.sample), 0);
    chk("reset_addr", int'(bus.rom_address), 0);
    idle(3, 1'b1);

    // Regular ticks stepping one ROM entry at a time.
    for (int i = 0; i < 8; i++) begin
      do_tick(1'b1, 32'h0100_0000, 4'd15);
      chk("step_addr", int'(bus.rom_address), i);
      wait_valid("step_valid", s);
      if (i == 0) chk("first_sample", s, 0);
      idle(1, 1'b1);
    end

    // Peak amplitudes at the positive and negative extremes of the table.
    idle(2, 1'b0);
    do_tick(1'b1, 32'h4000_0000, 4'd0);
    wait_valid("peak_prep", s);
    chk("vol0_sample", s, 0);
    do_tick(1'b1, 32'h8000_0000, 4'd15);
    chk("peak_addr", int'(bus.rom_address), 64);
    wait_valid("peak_pos", s);
    chk("peak_pos", s, 30705);
    do_tick(1'b1, 32'h0000_0000, 4'd1);
    chk("trough_addr", int'(bus.rom_address), 192);
    wait_valid("peak_neg", s);
    chk("peak_neg", s, -2047);

    // Gate off forces a silent sample and keeps phase at zero.
    idle(2, 1'b0);
    do_tick(1'b0, 32'h0300_0000, 4'd15);
    chk("gateoff_addr", int'(bus.rom_address), 0);
    wait_valid("gateoff_valid", s);
    chk("gateoff_sample", s, 0);
    do_tick(1'b1, 32'h0100_0000, 4'd15);
    chk("gateon_addr", int'(bus.rom_address), 0);
    wait_valid("gateon_valid", s);

    // Half-cycle tune word wraps the accumulator every second tick.
    idle(2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b1, 32'h8000_0000, 4'd7);
      chk("wrap_addr", int'(bus.rom_address), (i == 1) ? 8'h80 : 8'h00);
      wait_valid("wrap_valid", s);
    end

    // Back-to-back ticks: second is dropped and overrun latches.
    @(posedge clk);
    #1;
    bus.sample_tick = 1'b1;
    bus.volume      = 4'd9;
    @(posedge clk);
    #1;
    bus.volume      = 4'd3;
    bus.tune_word   = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.sample_tick = 1'b0;
    wait_valid("overrun_valid", s);
    idle(4, 1'b1);
    chk("overrun_sticky", int'(bus.overrun), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("overrun_cleared", int'(bus.overrun), 0);

    // Randomized traffic including mid-request changes, gate drops and resets.
    bus.gate = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      bus.sample_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) bus.gate = ~bus.gate;
      if ($urandom_range(0, 3) == 0)  bus.tune_word = $urandom;
      bus.volume = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 96) == 0);
    end
    @(posedge clk);
    #1;
    rst             = 1'b0;
    bus.sample_tick = 1'b0;
    idle(6, 1'b1);
    chk("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
